w_stage_grf: RTL and testbench

Writeback stage plus general register file for the five-stage MIPS pipeline. Consumes the M/W pipeline register outputs, decodes the destination register and write data, extends sub-word loads, and commits results into a 32×32 register file at the clock edge. Also provides the two D-stage read ports with same-cycle write-through bypass, and exports the effective write address, data and enable to the hazard/forwarding unit.

---
 rtl/w_stage_grf.sv | 198 +++++++++++++++++++
 tb/tb_w_stage_grf.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_stage_grf.sv
// Writeback stage and 32x32 general register file with write-through read ports.
// Optional commit trace compiled in with GRF_TRACE_EN.
module w_stage_grf (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_W,
    input  logic [31:0] PC_W,
    input  logic [31:0] PC8_W,
    input  logic [31:0] AO_W,
    input  logic [31:0] DR_W,
    input  logic        COND_W,
    input  logic [4:0]  A1_D,
    input  logic [4:0]  A2_D,
    output logic [31:0] RD1_D,
    output logic [31:0] RD2_D,
    output logic [4:0]  WA_W,
    output logic [31:0] WD_W,
    output logic        WE_W
);

    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpJal     = 6'h03;
    localparam logic [5:0] OpLb      = 6'h20;
    localparam logic [5:0] OpLh      = 6'h21;
    localparam logic [5:0] OpLw      = 6'h23;
    localparam logic [5:0] OpLbu     = 6'h24;
    localparam logic [5:0] OpLhu     = 6'h25;

    localparam logic [5:0] FnJalr = 6'h09;
    localparam logic [5:0] FnMovz = 6'h0A;
    localparam logic [5:0] FnMovn = 6'h0B;

    typedef enum logic [1:0] {
        SrcAlu,
        SrcLink,
        SrcMem
    } wd_src_e;

    typedef enum logic [2:0] {
        LdWord,
        LdByte,
        LdByteU,
        LdHalf,
        LdHalfU
    } ld_kind_e;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  wa;
    wd_src_e     wd_src;
    ld_kind_e    ld_kind;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data;
    logic [31:0] wd;

    logic [31:0] regs_q [32];

    assign opcode = IR_W[31:26];
    assign funct  = IR_W[5:0];
    assign rt     = IR_W[20:16];
    assign rd     = IR_W[15:11];

    // Destination and data-source decode
    always_comb begin
        wa      = 5'd0;
        wd_src  = SrcAlu;
        ld_kind = LdWord;
        case (opcode)
            OpSpecial: begin
                case (funct)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h10, 6'h12: begin
                        wa = rd;
                    end
                    FnJalr: begin
                        wa     = rd;
                        wd_src = SrcLink;
                    end
                    FnMovz, FnMovn: begin
                        wa = COND_W ? rd : 5'd0;
                    end
                    default: wa = 5'd0;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                wa = rt;
            end
            OpLw: begin
                wa      = rt;
                wd_src  = SrcMem;
                ld_kind = LdWord;
            end
            OpLb: begin
                wa      = rt;
                wd_src  = SrcMem;
                ld_kind = LdByte;
            end
            OpLbu: begin
                wa      = rt;
                wd_src  = SrcMem;
                ld_kind = LdByteU;
            end
            OpLh: begin
                wa      = rt;
                wd_src  = SrcMem;
                ld_kind = LdHalf;
            end
            OpLhu: begin
                wa      = rt;
                wd_src  = SrcMem;
                ld_kind = LdHalfU;
            end
            OpJal: begin
                wa     = 5'd31;
                wd_src = SrcLink;
            end
            default: wa = 5'd0;
        endcase
    end

    // Little-endian sub-word extraction
    always_comb begin
        case (AO_W[1:0])
            2'd0:    byte_sel = DR_W[7:0];
            2'd1:    byte_sel = DR_W[15:8];
            2'd2:    byte_sel = DR_W[23:16];
            default: byte_sel = DR_W[31:24];
        endcase
        half_sel = AO_W[1] ? DR_W[31:16] : DR_W[15:0];
        case (ld_kind)
            LdByte:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            LdByteU: ld_data = {24'd0, byte_sel};
            LdHalf:  ld_data = {{16{half_sel[15]}}, half_sel};
            LdHalfU: ld_data = {16'd0, half_sel};
            default: ld_data = DR_W;
        endcase
    end

    always_comb begin
        case (wd_src)
            SrcLink: wd = PC8_W;
            SrcMem:  wd = ld_data;
            default: wd = AO_W;
        endcase
    end

    assign WA_W = wa;
    assign WD_W = wd;
    assign WE_W = (wa != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (WE_W) begin
            regs_q[WA_W] <= WD_W;
        end
    end

    // Write-through: a reader of the W-stage target sees the value being committed
    always_comb begin
        if (A1_D == 5'd0) begin
            RD1_D = 32'd0;
        end else if (WE_W && (A1_D == WA_W)) begin
            RD1_D = WD_W;
        end else begin
            RD1_D = regs_q[A1_D];
        end
    end

    always_comb begin
        if (A2_D == 5'd0) begin
            RD2_D = 32'd0;
        end else if (WE_W && (A2_D == WA_W)) begin
            RD2_D = WD_W;
        end else begin
            RD2_D = regs_q[A2_D];
        end
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && WE_W) begin
            $display("%d@%h: $%d <= %h", $time, PC_W, WA_W, WD_W);
        end
    end
`endif

    // rs and shamt fields are not needed in writeback; PC_W only feeds the trace
    logic unused_bits;
    assign unused_bits = ^{PC_W, IR_W[25:21], IR_W[10:6]};

endmodule

// File: tb/tb_w_stage_grf.sv
// Directed bench for w_stage_grf: architectural register model plus literal spot checks.
module tb_w_stage_grf;

    logic        clk;
    logic        reset;
    logic [31:0] IR_W;
    logic [31:0] PC_W;
    logic [31:0] PC8_W;
    logic [31:0] AO_W;
    logic [31:0] DR_W;
    logic        COND_W;
    logic [4:0]  A1_D;
    logic [4:0]  A2_D;
    logic [31:0] RD1_D;
    logic [31:0] RD2_D;
    logic [4:0]  WA_W;
    logic [31:0] WD_W;
    logic        WE_W;

    int vectors;
    int miscompares;
    bit chk_en;

    logic [31:0] model_regs [32];

    w_stage_grf dut (
        .clk    (clk),
        .reset  (reset),
        .IR_W   (IR_W),
        .PC_W   (PC_W),
        .PC8_W  (PC8_W),
        .AO_W   (AO_W),
        .DR_W   (DR_W),
        .COND_W (COND_W),
        .A1_D   (A1_D),
        .A2_D   (A2_D),
        .RD1_D  (RD1_D),
        .RD2_D  (RD2_D),
        .WA_W   (WA_W),
        .WD_W   (WD_W),
        .WE_W   (WE_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural writeback rule: returns {write address, write data}; address 0 = no write
    function automatic logic [36:0] model_write(input logic [31:0] ir, input logic [31:0] ao,
                                                input logic [31:0] dr, input logic [31:0] pc8,
                                                input logic cond);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  dst;
        logic [31:0] val;
        logic [31:0] piece;
        op    = ir[31:26];
        fn    = ir[5:0];
        dst   = 5'd0;
        val   = ao;
        piece = 32'd0;
        if (op == 6'h00) begin
            if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                           6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12}) begin
                dst = ir[15:11];
            end else if (fn == 6'h09) begin
                dst = ir[15:11];
                val = pc8;
            end else if (fn == 6'h0A || fn == 6'h0B) begin
                dst = cond ? ir[15:11] : 5'd0;
            end
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            dst = ir[20:16];
        end else if (op == 6'h23) begin
            dst = ir[20:16];
            val = dr;
        end else if (op == 6'h20 || op == 6'h24) begin
            dst   = ir[20:16];
            piece = (dr >> (8 * ao[1:0])) & 32'h0000_00FF;
            val   = (op == 6'h20 && piece[7]) ? (piece | 32'hFFFF_FF00) : piece;
        end else if (op == 6'h21 || op == 6'h25) begin
            dst   = ir[20:16];
            piece = (dr >> (16 * ao[1])) & 32'h0000_FFFF;
            val   = (op == 6'h21 && piece[15]) ? (piece | 32'hFFFF_0000) : piece;
        end else if (op == 6'h03) begin
            dst = 5'd31;
            val = pc8;
        end
        return {dst, val};
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic [36:0] w);
        if (a == 5'd0) return 32'd0;
        if (w[36:32] != 5'd0 && w[36:32] == a) return w[31:0];
        return model_regs[a];
    endfunction

    always @(posedge clk) begin
        logic [36:0] w;
        w = model_write(IR_W, AO_W, DR_W, PC8_W, COND_W);
        if (reset) begin
            for (int i = 0; i < 32; i++) model_regs[i] <= 32'd0;
        end else if (w[36:32] != 5'd0) begin
            model_regs[w[36:32]] <= w[31:0];
        end
    end

    always @(negedge clk) begin
        logic [36:0] w;
        if (chk_en) begin
            w = model_write(IR_W, AO_W, DR_W, PC8_W, COND_W);
            check("wa", 32'(WA_W), 32'(w[36:32]));
            check("we", 32'(WE_W), 32'(w[36:32] != 5'd0));
            if (w[36:32] != 5'd0) check("wd", WD_W, w[31:0]);
            check("rd1", RD1_D, model_read(A1_D, w));
            check("rd2", RD2_D, model_read(A2_D, w));
        end
    end

    task automatic drive(input logic [31:0] ir, input logic [31:0] ao, input logic [31:0] dr,
                         input logic cond, input logic [4:0] a1, input logic [4:0] a2);
        IR_W   = ir;
        AO_W   = ao;
        DR_W   = dr;
        COND_W = cond;
        A1_D   = a1;
        A2_D   = a2;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, 5'd0, rt, imm};
    endfunction

    logic [5:0] fn_list [21];

    initial begin
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        reset       = 1'b1;
        IR_W        = 32'd0;
        PC_W        = 32'h0000_3000;
        PC8_W       = 32'h0000_3008;
        AO_W        = 32'd0;
        DR_W        = 32'd0;
        COND_W      = 1'b0;
        A1_D        = 5'd0;
        A2_D        = 5'd0;
        fn_list = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12, 6'h09, 6'h08,
                    6'h0C};
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        reset = 1'b0;

        // Every register reads 0 after reset, on both ports
        for (int a = 0; a < 32; a++) begin
            drive(32'd0, 32'hA5A5_0000, 32'd0, 1'b0, 5'(a), 5'(31 - a));
            check("reset_rd1", RD1_D, 32'd0);
            check("reset_rd2", RD2_D, 32'd0);
            check("idle_wd", WD_W, 32'hA5A5_0000);
            next_cycle();
        end

        // ori $5,$0,0x1234: bypass then storage
        drive(itype(6'h0D, 5'd5, 16'h1234), 32'h0000_1234, 32'd0, 1'b0, 5'd5, 5'd0);
        check("ori_we", 32'(WE_W), 32'd1);
        check("ori_wa", 32'(WA_W), 32'd5);
        check("ori_bypass", RD1_D, 32'h0000_1234);
        next_cycle();
        drive(32'd0, 32'd0, 32'd0, 1'b0, 5'd5, 5'd5);
        check("ori_stored", RD1_D, 32'h0000_1234);
        next_cycle();

        // Sub-word loads from 0x8899AABB
        drive(itype(6'h20, 5'd8, 16'h2), 32'h0000_1002, 32'h8899_AABB, 1'b0, 5'd8, 5'd0);
        check("lb", WD_W, 32'hFFFF_FF99);
        next_cycle();
        drive(itype(6'h24, 5'd8, 16'h2), 32'h0000_1002, 32'h8899_AABB, 1'b0, 5'd8, 5'd0);
        check("lbu", WD_W, 32'h0000_0099);
        next_cycle();
        drive(itype(6'h21, 5'd8, 16'h2), 32'h0000_1002, 32'h8899_AABB, 1'b0, 5'd8, 5'd0);
        check("lh", WD_W, 32'hFFFF_8899);
        next_cycle();
        drive(itype(6'h25, 5'd8, 16'h0), 32'h0000_1000, 32'h8899_AABB, 1'b0, 5'd8, 5'd0);
        check("lhu", WD_W, 32'h0000_AABB);
        next_cycle();
        drive(itype(6'h23, 5'd8, 16'h1), 32'h0000_1001, 32'h8899_AABB, 1'b0, 5'd8, 5'd0);
        check("lw", WD_W, 32'h8899_AABB);
        next_cycle();
        for (int off = 0; off < 4; off++) begin
            drive(itype(6'h20, 5'(10 + off), 16'(off)), 32'(off), 32'h7F80_01FE, 1'b0,
                  5'(10 + off), 5'd8);
            next_cycle();
            drive(itype(6'h21, 5'(14 + off), 16'(off)), 32'(off), 32'h7F80_01FE, 1'b0,
                  5'(10 + off), 5'(14 + off));
            next_cycle();
        end

        // jal links into $31; jalr to $0 commits nothing
        PC8_W = 32'h0000_3008;
        drive({6'h03, 26'h0000C00}, 32'h1111_1111, 32'd0, 1'b0, 5'd31, 5'd0);
        check("jal_wa", 32'(WA_W), 32'd31);
        check("jal_wd", WD_W, 32'h0000_3008);
        next_cycle();
        drive(32'd0, 32'd0, 32'd0, 1'b0, 5'd31, 5'd0);
        check("jal_stored", RD1_D, 32'h0000_3008);
        next_cycle();
        PC8_W = 32'h0000_4010;
        drive(rtype(5'd0, 6'h09), 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        check("jalr0_we", 32'(WE_W), 32'd0);
        next_cycle();
        drive(32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        check("r0_zero", RD1_D, 32'd0);
        next_cycle();

        // movz/movn commit only with COND_W
        drive(rtype(5'd7, 6'h0A), 32'hDEAD_0007, 32'd0, 1'b0, 5'd7, 5'd0);
        check("movz_nc_we", 32'(WE_W), 32'd0);
        next_cycle();
        drive(32'd0, 32'd0, 32'd0, 1'b0, 5'd7, 5'd0);
        check("movz_nc_keep", RD1_D, 32'd0);
        next_cycle();
        drive(rtype(5'd7, 6'h0A), 32'hDEAD_0007, 32'd0, 1'b1, 5'd0, 5'd7);
        check("movz_c_wa", 32'(WA_W), 32'd7);
        next_cycle();
        drive(32'd0, 32'd0, 32'd0, 1'b0, 5'd7, 5'd0);
        check("movz_c_stored", RD1_D, 32'hDEAD_0007);
        next_cycle();
        drive(rtype(5'd7, 6'h0B), 32'h0BAD_F00D, 32'd0, 1'b0, 5'd7, 5'd7);
        next_cycle();
        drive(rtype(5'd6, 6'h0B), 32'h0BAD_F00D, 32'd0, 1'b1, 5'd6, 5'd7);
        next_cycle();

        // R-type and I-type sweep, including non-writing functs and opcodes
        PC8_W = 32'h0000_5008;
        for (int i = 0; i < 21; i++) begin
            drive(rtype(5'(i + 9), fn_list[i]), 32'h1000_0000 + 32'(i), 32'd0, 1'b0,
                  5'(i + 9), 5'(i + 8));
            next_cycle();
        end
        for (int op = 6'h08; op <= 6'h0F; op++) begin
            drive(itype(6'(op), 5'(op + 8), 16'hBEEF), 32'h2000_0000 + 32'(op), 32'd0, 1'b0,
                  5'(op + 7), 5'(op + 8));
            next_cycle();
        end
        drive(itype(6'h2B, 5'd3, 16'h0), 32'h3333_3333, 32'd0, 1'b0, 5'd3, 5'd0);
        check("sw_we", 32'(WE_W), 32'd0);
        next_cycle();
        drive(itype(6'h04, 5'd3, 16'h0), 32'h3333_3333, 32'd0, 1'b0, 5'd3, 5'd0);
        next_cycle();

        // Both ports on the write target
        drive(rtype(5'd9, 6'h21), 32'h0000_0055, 32'd0, 1'b0, 5'd9, 5'd9);
        check("dual_bypass1", RD1_D, 32'h0000_0055);
        check("dual_bypass2", RD2_D, 32'h0000_0055);
        next_cycle();

        // Reset overrides the write in the same cycle
        reset = 1'b1;
        drive(rtype(5'd9, 6'h21), 32'h0000_0077, 32'd0, 1'b0, 5'd9, 5'd31);
        next_cycle();
        reset = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 1'b0, 5'd9, 5'd31);
        check("reset_drops_9", RD1_D, 32'd0);
        check("reset_clears_31", RD2_D, 32'd0);
        next_cycle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
